// File: rtl/key_filter_pkg.sv
// Shared types and sizing helpers for the multi-channel key debouncer.
package key_filter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_HELD       = 3'd2,
    ST_LONG       = 3'd3,
    ST_RELEASE_DB = 3'd4
  } key_state_e;

  // One counter width covers debounce, long-press and repeat timing.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_filter_chan.sv
// One key channel: 2-flop synchroniser, debounce/long/repeat FSM, registered events.
module key_filter_chan
  import key_filter_pkg::*;
#(
  parameter int CNT_MAX    = 999_999,
  parameter int LONG_MAX   = 49_999_999,
  parameter int REPEAT_MAX = 9_999_999,
  parameter int REPEAT_EN  = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic sys_clock,
  input  logic sys_rst,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int             CW        = cnt_width(CNT_MAX, LONG_MAX, REPEAT_MAX);
  localparam logic [CW-1:0]  CNT_END   = CW'(CNT_MAX);
  localparam logic [CW-1:0]  LONG_END  = CW'(LONG_MAX);
  localparam logic [CW-1:0]  REP_END   = CW'(REPEAT_MAX);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic           REL_LEVEL = (ACTIVE_LOW != 0);
  localparam logic           REP_ON    = (REPEAT_EN != 0);

  logic [1:0]    sync_q;
  key_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          long_seen_q;
  logic          level_q, press_q, release_q, long_q, repeat_q;
  logic          pressed;

  // XOR with the released level folds the polarity choice into one gate.
  assign pressed = sync_q[1] ^ REL_LEVEL;

  // NOTE: all state lives in one clocked block with non-blocking updates, so every
  // read of state_q/cnt_q sees the pre-edge value regardless of statement order.
  always_ff @(posedge sys_clock) begin
    if (sys_rst) begin
      // NOTE: the synchroniser resets to the released pin level, otherwise a
      // reset could look like a press to the FSM on the first cycles after it.
      sync_q      <= {2{REL_LEVEL}};
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      long_seen_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_i};
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (pressed) begin
            state_q <= ST_PRESS_DB;
            cnt_q   <= '0;
          end
        end
        ST_PRESS_DB: begin
          if (!pressed) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_END) begin
            state_q <= ST_HELD;
            cnt_q   <= '0;
            press_q <= 1'b1;
            level_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_HELD: begin
          if (!pressed) begin
            state_q <= ST_RELEASE_DB;
            cnt_q   <= '0;
          end else if (cnt_q == LONG_END) begin
            state_q     <= ST_LONG;
            cnt_q       <= '0;
            long_q      <= 1'b1;
            long_seen_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_LONG: begin
          if (!pressed) begin
            state_q <= ST_RELEASE_DB;
            cnt_q   <= '0;
          end else if (cnt_q == REP_END) begin
            // Without repeat the counter parks at its end value.
            if (REP_ON) begin
              repeat_q <= 1'b1;
              cnt_q    <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_RELEASE_DB: begin
          if (pressed) begin
            state_q <= long_seen_q ? ST_LONG : ST_HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_END) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            release_q   <= 1'b1;
            level_q     <= 1'b0;
            long_seen_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_filter_multi.sv
// Multi-channel key debouncer: NUM_KEYS independent key_filter_chan instances.
module key_filter_multi
  import key_filter_pkg::*;
#(
  parameter int NUM_KEYS   = 4,
  parameter int CNT_MAX    = 999_999,
  parameter int LONG_MAX   = 49_999_999,
  parameter int REPEAT_MAX = 9_999_999,
  parameter int REPEAT_EN  = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                sys_clock,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat
);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    key_filter_chan #(
      .CNT_MAX   (CNT_MAX),
      .LONG_MAX  (LONG_MAX),
      .REPEAT_MAX(REPEAT_MAX),
      .REPEAT_EN (REPEAT_EN),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_chan (
      .sys_clock(sys_clock),
      .sys_rst  (sys_rst),
      .key_i    (key_in[k]),
      .level_o  (key_level[k]),
      .press_o  (key_press[k]),
      .release_o(key_release[k]),
      .long_o   (key_long[k]),
      .repeat_o (key_repeat[k])
    );
  end

endmodule

// File: tb/tb_key_filter_multi.sv
// Scoreboard bench for key_filter_multi: an active-low/repeat instance and an active-high/no-repeat instance.
module tb_key_filter_multi;

  localparam int NK = 4;
  localparam int CM = 9;
  localparam int LM = 49;
  localparam int RM = 19;

  logic          sys_clock = 1'b0;
  logic          sys_rst   = 1'b1;
  logic [NK-1:0] key_a     = '1;
  logic [NK-1:0] key_b     = '0;
  logic [NK-1:0] lvl_a, prs_a, rel_a, lng_a, rep_a;
  logic [NK-1:0] lvl_b, prs_b, rel_b, lng_b, rep_b;

  key_filter_multi #(
    .NUM_KEYS(NK), .CNT_MAX(CM), .LONG_MAX(LM), .REPEAT_MAX(RM),
    .REPEAT_EN(1), .ACTIVE_LOW(1)
  ) dut_a (
    .sys_clock(sys_clock), .sys_rst(sys_rst), .key_in(key_a),
    .key_level(lvl_a), .key_press(prs_a), .key_release(rel_a),
    .key_long(lng_a), .key_repeat(rep_a)
  );

  key_filter_multi #(
    .NUM_KEYS(NK), .CNT_MAX(CM), .LONG_MAX(LM), .REPEAT_MAX(RM),
    .REPEAT_EN(0), .ACTIVE_LOW(0)
  ) dut_b (
    .sys_clock(sys_clock), .sys_rst(sys_rst), .key_in(key_b),
    .key_level(lvl_b), .key_press(prs_b), .key_release(rel_b),
    .key_long(lng_b), .key_repeat(rep_b)
  );

  always #5 sys_clock = ~sys_clock;

  int cyc = 0;
  always @(posedge sys_clock) cyc++;

  typedef enum {EV_PRESS, EV_RELEASE, EV_LONG, EV_REPEAT, EV_RST} ev_kind_e;
  typedef struct {
    int       edge_n;
    int       dut;
    int       ch;
    ev_kind_e kind;
  } ev_t;

  ev_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic push_ev(input int e, input int d, input int ch, input ev_kind_e k);
    ev_t t;
    t.edge_n = e;
    t.dut    = d;
    t.ch     = ch;
    t.kind   = k;
    sb.push_back(t);
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) @(negedge sys_clock);
  endtask

  // Scoreboard monitor: pops events due at this edge, compares all outputs.
  logic [NK-1:0] ep [2];
  logic [NK-1:0] er [2];
  logic [NK-1:0] el [2];
  logic [NK-1:0] et [2];
  logic [NK-1:0] ex_lvl [2] = '{'0, '0};
  logic [NK-1:0] o_l, o_p, o_r, o_g, o_t;

  always @(negedge sys_clock) begin
    if (cyc > 0) begin
      for (int d = 0; d < 2; d++) begin
        ep[d] = '0; er[d] = '0; el[d] = '0; et[d] = '0;
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].edge_n == cyc) begin
          case (sb[i].kind)
            EV_PRESS:   begin ep[sb[i].dut][sb[i].ch] = 1'b1; ex_lvl[sb[i].dut][sb[i].ch] = 1'b1; end
            EV_RELEASE: begin er[sb[i].dut][sb[i].ch] = 1'b1; ex_lvl[sb[i].dut][sb[i].ch] = 1'b0; end
            EV_LONG:    el[sb[i].dut][sb[i].ch] = 1'b1;
            EV_REPEAT:  et[sb[i].dut][sb[i].ch] = 1'b1;
            EV_RST:     ex_lvl[sb[i].dut] = '0;
            default:    ;
          endcase
          sb.delete(i);
        end
      end
      for (int d = 0; d < 2; d++) begin
        o_l = (d == 0) ? lvl_a : lvl_b;
        o_p = (d == 0) ? prs_a : prs_b;
        o_r = (d == 0) ? rel_a : rel_b;
        o_g = (d == 0) ? lng_a : lng_b;
        o_t = (d == 0) ? rep_a : rep_b;
        n_cmp += 5;
        if (o_l !== ex_lvl[d]) begin
          n_bad++;
          $display("FAIL level dut%0d edge %0d: got %b expected %b", d, cyc, o_l, ex_lvl[d]);
        end
        if (o_p !== ep[d]) begin
          n_bad++;
          $display("FAIL press dut%0d edge %0d: got %b expected %b", d, cyc, o_p, ep[d]);
        end
        if (o_r !== er[d]) begin
          n_bad++;
          $display("FAIL release dut%0d edge %0d: got %b expected %b", d, cyc, o_r, er[d]);
        end
        if (o_g !== el[d]) begin
          n_bad++;
          $display("FAIL long dut%0d edge %0d: got %b expected %b", d, cyc, o_g, el[d]);
        end
        if (o_t !== et[d]) begin
          n_bad++;
          $display("FAIL repeat dut%0d edge %0d: got %b expected %b", d, cyc, o_t, et[d]);
        end
      end
    end
  end

  task automatic check_drained(input string name);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s drained: %0d events left, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clock);
    n_cmp++;
    if ({lvl_a, prs_a, rel_a, lng_a, rep_a, lvl_b, prs_b, rel_b, lng_b, rep_b} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
    end
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clock);
  endtask

  task automatic test_clean_press();
    int base;
    base = cyc;
    key_a[0] = 1'b0;
    push_ev(base + 13, 0, 0, EV_PRESS);
    push_ev(base + 43, 0, 0, EV_RELEASE);
    wait_until(base + 20);
    n_cmp++;
    if (lvl_a !== 4'b0001) begin
      n_bad++;
      $display("FAIL clean_level: got %b expected 0001", lvl_a);
    end
    wait_until(base + 30);
    key_a[0] = 1'b1;
    wait_until(base + 50);
    check_drained("clean_press");
  endtask

  task automatic test_bounce();
    for (int s = 0; s < 8; s++) begin
      key_a[1] = s[0];
      for (int k = 0; k < 5; k++) begin
        @(negedge sys_clock);
        n_cmp++;
        if (lvl_a[1] !== 1'b0) begin
          n_bad++;
          $display("FAIL bounce_level: got %b expected 0", lvl_a[1]);
        end
      end
    end
    repeat (20) @(negedge sys_clock);
    check_drained("bounce");
  endtask

  task automatic test_long_repeat();
    int base;
    base = cyc;
    key_a[2] = 1'b0;
    push_ev(base + 13, 0, 2, EV_PRESS);
    push_ev(base + 63, 0, 2, EV_LONG);
    for (int r = 0; r < 4; r++) push_ev(base + 83 + 20 * r, 0, 2, EV_REPEAT);
    push_ev(base + 163, 0, 2, EV_RELEASE);
    wait_until(base + 150);
    key_a[2] = 1'b1;
    wait_until(base + 170);
    check_drained("long_repeat");
  endtask

  task automatic test_release_glitch();
    int base;
    base = cyc;
    key_a[3] = 1'b0;
    push_ev(base + 13, 0, 3, EV_PRESS);
    push_ev(base + 63, 0, 3, EV_LONG);
    push_ev(base + 83, 0, 3, EV_REPEAT);
    push_ev(base + 117, 0, 3, EV_REPEAT);
    push_ev(base + 137, 0, 3, EV_REPEAT);
    push_ev(base + 152, 0, 3, EV_RELEASE);
    wait_until(base + 89);
    key_a[3] = 1'b1;
    wait_until(base + 94);
    key_a[3] = 1'b0;
    wait_until(base + 100);
    n_cmp++;
    if (lvl_a[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_level: got %b expected 1", lvl_a[3]);
    end
    wait_until(base + 139);
    key_a[3] = 1'b1;
    wait_until(base + 160);
    check_drained("release_glitch");
  endtask

  task automatic test_reset_mid_hold();
    int base;
    base = cyc;
    key_a[0] = 1'b0;
    push_ev(base + 13, 0, 0, EV_PRESS);
    push_ev(base + 30, 0, 0, EV_RST);
    push_ev(base + 30, 1, 0, EV_RST);
    push_ev(base + 43, 0, 0, EV_PRESS);
    push_ev(base + 73, 0, 0, EV_RELEASE);
    wait_until(base + 29);
    sys_rst = 1'b1;
    wait_until(base + 30);
    n_cmp++;
    if ({lvl_a, prs_a, rel_a, lng_a, rep_a} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got nonzero, expected all 0 (level %b)", lvl_a);
    end
    sys_rst = 1'b0;
    wait_until(base + 60);
    key_a[0] = 1'b1;
    wait_until(base + 80);
    check_drained("reset_mid_hold");
  endtask

  task automatic test_variant_no_repeat();
    int base;
    base = cyc;
    key_b[0] = 1'b1;
    push_ev(base + 13, 1, 0, EV_PRESS);
    push_ev(base + 63, 1, 0, EV_LONG);
    push_ev(base + 113, 1, 0, EV_RELEASE);
    wait_until(base + 100);
    key_b[0] = 1'b0;
    wait_until(base + 125);
    check_drained("variant_no_repeat");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_release_glitch();
    test_reset_mid_hold();
    test_variant_no_repeat();
    @(negedge sys_clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
